// File: rtl/video_timing_pkg.sv
// Raster timing descriptors shared by the video timing generator and its users.
package video_timing_pkg;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_active;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
        logic        h_pol;
        logic        v_pol;
    } video_timing_t;

    localparam video_timing_t TIMING_1280x720 = '{
        h_active: 16'd1280, h_fp: 16'd110, h_sync: 16'd40, h_bp: 16'd220,
        v_active: 16'd720,  v_fp: 16'd5,   v_sync: 16'd5,  v_bp: 16'd20,
        h_pol: 1'b1, v_pol: 1'b1};

    localparam video_timing_t TIMING_640x480 = '{
        h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
        v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33,
        h_pol: 1'b0, v_pol: 1'b0};

    localparam video_timing_t TIMING_TINY = '{
        h_active: 16'd8, h_fp: 16'd2, h_sync: 16'd2, h_bp: 16'd2,
        v_active: 16'd4, v_fp: 16'd1, v_sync: 16'd1, v_bp: 16'd1,
        h_pol: 1'b1, v_pol: 1'b0};

    function automatic logic [17:0] h_total(input video_timing_t t);
        return 18'(t.h_active) + 18'(t.h_fp) + 18'(t.h_sync) + 18'(t.h_bp);
    endfunction

    function automatic logic [17:0] v_total(input video_timing_t t);
        return 18'(t.v_active) + 18'(t.v_fp) + 18'(t.v_sync) + 18'(t.v_bp);
    endfunction

    function automatic logic fields_ok(input video_timing_t t);
        return (t.h_active != 16'd0) && (t.h_fp != 16'd0) && (t.h_sync != 16'd0) &&
               (t.h_bp != 16'd0) && (t.v_active != 16'd0) && (t.v_fp != 16'd0) &&
               (t.v_sync != 16'd0) && (t.v_bp != 16'd0);
    endfunction

endpackage

// File: rtl/video_pipe_delay.sv
// Enable-gated shift register of DEPTH stages; DEPTH=0 is a plain wire.
// Synchronous clear loads clr_val into every stage.
module video_pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             pixel_clk,
    input  logic             rst,
    input  logic             clken,
    input  logic [WIDTH-1:0] clr_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ctl;
            assign unused_ctl = ^{pixel_clk, rst, clken, clr_val};
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stages [DEPTH];

            always_ff @(posedge pixel_clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stages[i] <= clr_val;
                end else if (clken) begin
                    stages[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
                end
            end

            assign q = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Dual-mode raster timing generator; mode switches only at the (0,0) frame wrap.
// Outputs are registered plus PIPE_DELAY extra enabled stages, all fields aligned.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int            HW         = 12,
    parameter int            VW         = 11,
    parameter video_timing_t MODE0      = TIMING_1280x720,
    parameter video_timing_t MODE1      = TIMING_640x480,
    parameter int            PIPE_DELAY = 0
) (
    input  logic          pixel_clk,
    input  logic          rst,
    input  logic          clken,
    input  logic          mode_sel,
    output logic          mode_cur,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic          fsync,
    output logic          lsync,
    output logic [HW-1:0] hpos,
    output logic [VW-1:0] vpos
);

    if (PIPE_DELAY < 0 || PIPE_DELAY > 8) begin : g_bad_delay
        $error("video_timing_gen: PIPE_DELAY must be 0..8");
    end
    if (int'(h_total(MODE0)) > (1 << HW) || int'(h_total(MODE1)) > (1 << HW)) begin : g_bad_hw
        $error("video_timing_gen: horizontal total exceeds counter range");
    end
    if (int'(v_total(MODE0)) > (1 << VW) || int'(v_total(MODE1)) > (1 << VW)) begin : g_bad_vw
        $error("video_timing_gen: vertical total exceeds counter range");
    end
    if (!fields_ok(MODE0) || !fields_ok(MODE1)) begin : g_bad_field
        $error("video_timing_gen: every timing field must be >= 1");
    end

    // hs/vs are stored already polarity-applied so every stage carries final levels
    typedef struct packed {
        logic          mode;
        logic          act;
        logic          hs;
        logic          vs;
        logic          fs;
        logic          ls;
        logic [HW-1:0] hpos;
        logic [VW-1:0] vpos;
    } stage_t;

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          mode_q;
    video_timing_t tim;
    logic [17:0]   hx, vx, hs_beg, hs_end, vs_beg, vs_end;
    logic          h_last, v_last;
    stage_t        dec, clr, s1, s_out;

    assign tim    = mode_q ? MODE1 : MODE0;
    assign hx     = 18'(h);
    assign vx     = 18'(v);
    assign h_last = (hx == h_total(tim) - 18'd1);
    assign v_last = (vx == v_total(tim) - 18'd1);
    assign hs_beg = 18'(tim.h_active) + 18'(tim.h_fp);
    assign hs_end = hs_beg + 18'(tim.h_sync);
    assign vs_beg = 18'(tim.v_active) + 18'(tim.v_fp);
    assign vs_end = vs_beg + 18'(tim.v_sync);

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            h      <= '0;
            v      <= '0;
            mode_q <= mode_sel;
        end else if (clken) begin
            if (h_last) begin
                h <= '0;
                if (v_last) begin
                    v      <= '0;
                    mode_q <= mode_sel;
                end else begin
                    v <= v + VW'(1);
                end
            end else begin
                h <= h + HW'(1);
            end
        end
    end

    always_comb begin
        dec      = '0;
        dec.mode = mode_q;
        dec.act  = (hx < 18'(tim.h_active)) && (vx < 18'(tim.v_active));
        dec.hs   = ((hx >= hs_beg) && (hx < hs_end)) ^ ~tim.h_pol;
        dec.vs   = ((vx >= vs_beg) && (vx < vs_end)) ^ ~tim.v_pol;
        dec.fs   = (h == '0) && (v == '0);
        dec.ls   = (h == '0);
        dec.hpos = h;
        dec.vpos = v;
    end

    // Cleared stages show idle sync levels of the mode being loaded
    always_comb begin
        clr      = '0;
        clr.mode = mode_sel;
        clr.hs   = mode_sel ? ~MODE1.h_pol : ~MODE0.h_pol;
        clr.vs   = mode_sel ? ~MODE1.v_pol : ~MODE0.v_pol;
    end

    always_ff @(posedge pixel_clk) begin
        if (rst)        s1 <= clr;
        else if (clken) s1 <= dec;
    end

    video_pipe_delay #(
        .WIDTH($bits(stage_t)),
        .DEPTH(PIPE_DELAY)
    ) u_pipe (
        .pixel_clk(pixel_clk),
        .rst      (rst),
        .clken    (clken),
        .clr_val  (clr),
        .d        (s1),
        .q        (s_out)
    );

    assign mode_cur = s_out.mode;
    assign active   = s_out.act;
    assign hsync    = s_out.hs;
    assign vsync    = s_out.vs;
    assign fsync    = s_out.fs;
    assign lsync    = s_out.ls;
    assign hpos     = s_out.hpos;
    assign vpos     = s_out.vpos;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: TINY raster at delay 0 and 3, clken gating, mid-frame reset,
// frame-boundary mode switch to 640x480, and mode_sel held through reset.
module tb_video_timing_gen;
    import video_timing_pkg::*;

    logic pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    logic rst, clken, mode_sel, rst_b, mode_sel_b;
    logic mode_cur0, hsync0, vsync0, active0, fsync0, lsync0;
    logic mode_cur3, hsync3, vsync3, active3, fsync3, lsync3;
    logic mode_cur_b, hsync_b, vsync_b, active_b, fsync_b, lsync_b;
    logic [11:0] hpos0, hpos3, hpos_b;
    logic [10:0] vpos0, vpos3, vpos_b;

    video_timing_gen #(.MODE0(TIMING_TINY), .MODE1(TIMING_640x480), .PIPE_DELAY(0)) dut0 (
        .pixel_clk(pixel_clk), .rst(rst), .clken(clken), .mode_sel(mode_sel),
        .mode_cur(mode_cur0), .hsync(hsync0), .vsync(vsync0), .active(active0),
        .fsync(fsync0), .lsync(lsync0), .hpos(hpos0), .vpos(vpos0));

    video_timing_gen #(.MODE0(TIMING_TINY), .MODE1(TIMING_640x480), .PIPE_DELAY(3)) dut3 (
        .pixel_clk(pixel_clk), .rst(rst), .clken(clken), .mode_sel(mode_sel),
        .mode_cur(mode_cur3), .hsync(hsync3), .vsync(vsync3), .active(active3),
        .fsync(fsync3), .lsync(lsync3), .hpos(hpos3), .vpos(vpos3));

    video_timing_gen #(.MODE0(TIMING_1280x720), .MODE1(TIMING_640x480), .PIPE_DELAY(0)) dut_b (
        .pixel_clk(pixel_clk), .rst(rst_b), .clken(1'b1), .mode_sel(mode_sel_b),
        .mode_cur(mode_cur_b), .hsync(hsync_b), .vsync(vsync_b), .active(active_b),
        .fsync(fsync_b), .lsync(lsync_b), .hpos(hpos_b), .vpos(vpos_b));

    // {mode_cur, active, hsync, vsync, fsync, lsync, hpos, vpos}
    localparam logic [28:0] RESET_VEC = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 11'd0};

    logic [28:0] obs0, obs3;
    assign obs0 = {mode_cur0, active0, hsync0, vsync0, fsync0, lsync0, hpos0, vpos0};
    assign obs3 = {mode_cur3, active3, hsync3, vsync3, fsync3, lsync3, hpos3, vpos3};

    int n_checks = 0;
    int n_errors = 0;
    int mh, mv, guard;
    int act_n, hs_n, vsl_n, fs_n;
    logic [28:0] hist [4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // TINY: 8 active px, hsync high at h=10..11; 4 active lines, vsync low on line 5
    function automatic logic [28:0] tiny_vec(input int h, input int v);
        logic a, hs, vs, fs, ls;
        a  = (h < 8) && (v < 4);
        hs = (h == 10) || (h == 11);
        vs = (v != 5);
        fs = (h == 0) && (v == 0);
        ls = (h == 0);
        return {1'b0, a, hs, vs, fs, ls, 12'(h), 11'(v)};
    endfunction

    task automatic step(input logic en);
        clken = en;
        @(posedge pixel_clk);
        #1;
        if (rst) begin
            mh = 0;
            mv = 0;
            for (int i = 0; i < 4; i++) hist[i] = RESET_VEC;
        end else if (en) begin
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = tiny_vec(mh, mv);
            mh++;
            if (mh == 14) begin
                mh = 0;
                mv = (mv == 6) ? 0 : mv + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_pd0"}, obs0, hist[0]);
        check({tag, "_pd3"}, obs3, hist[3]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", n_errors);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; clken = 1'b1; mode_sel = 1'b0;
        rst_b = 1'b1; mode_sel_b = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1);
        check("reset_pd0", obs0, RESET_VEC);
        check("reset_pd3", obs3, RESET_VEC);

        rst = 1'b0;
        step(1'b1);
        check("first_fsync", fsync0, 1);
        check_all("release");

        act_n = 0; hs_n = 0; vsl_n = 0; fs_n = 0;
        for (int i = 0; i < 98; i++) begin
            act_n += int'(active0);
            hs_n  += int'(hsync0);
            vsl_n += int'(!vsync0);
            fs_n  += int'(fsync0);
            step(1'b1);
            check_all("frame1");
        end
        check("fsync_period_98", fsync0, 1);
        check("fsync_per_frame", fs_n, 1);
        check("active_per_frame", act_n, 32);
        check("hsync_hi_per_frame", hs_n, 14);
        check("vsync_lo_per_frame", vsl_n, 14);

        for (int i = 0; i < 98; i++) begin
            step(1'b1);
            check_all("frame2");
        end

        for (int i = 0; i < 60; i++) begin
            step((i % 3) == 0);
            check_all("clken_1of3");
        end

        guard = 0;
        while (!(mh == 6 && mv == 2) && guard < 200) begin
            step(1'b1);
            check_all("seek_5_2");
            guard++;
        end
        check("at_h5_v2", {hpos0, vpos0}, {12'd5, 11'd2});
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        check("midrst_vec", obs0, RESET_VEC);
        check("midrst_hsync", hsync0, 0);
        check_all("midrst");
        step(1'b1);
        check("midrst_fsync", fsync0, 1);
        check_all("midrst_after");

        for (int i = 0; i < 50; i++) begin
            step(1'b1);
            check_all("pre_switch");
        end
        mode_sel = 1'b1;
        guard = 0;
        while (!(mh == 0 && mv == 0) && guard < 200) begin
            step(1'b1);
            check_all("switch_wait");
            guard++;
            if (guard == 10) mode_sel = 1'b0;
            if (guard == 20) mode_sel = 1'b1;
        end
        check("switch_wrap_reached", guard < 200, 1);

        tick();
        check("sw_fsync", fsync0, 1);
        check("sw_mode_cur", mode_cur0, 1);
        check("sw_hsync_idle", hsync0, 1);
        check("sw_active", active0, 1);
        act_n = int'(active0); hs_n = int'(!hsync0); fs_n = 0;
        for (int i = 1; i < 800; i++) begin
            tick();
            act_n += int'(active0);
            hs_n  += int'(!hsync0);
            fs_n  += int'(fsync0);
        end
        check("sw_active_per_line", act_n, 640);
        check("sw_hsync_lo_per_line", hs_n, 96);
        check("sw_no_extra_fsync", fs_n, 0);
        tick();
        check("sw_line_wrap", {hpos0, vpos0}, {12'd0, 11'd1});
        check("sw_lsync", lsync0, 1);

        check("b_rst_mode_cur", mode_cur_b, 1);
        check("b_rst_hsync", hsync_b, 1);
        check("b_rst_vsync", vsync_b, 1);
        check("b_rst_active", active_b, 0);
        rst_b = 1'b0;
        tick();
        check("b_first_fsync", fsync_b, 1);
        check("b_mode_cur", mode_cur_b, 1);
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!lsync_b && guard < 2000);
        check("b_line_len", guard, 800);
        check("b_vpos", vpos_b, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
